data_mem_responder: RTL
=======================

Name: data_mem_responder

Overview:
- Responder end of the processor's data-memory port: accepts MemRead/MemWrite strobes with dAddress/dWriteData and returns dReadData plus a completion handshake.
- Word-addressed RAM with configurable read/write latency, a small request FSM, and address-range/alignment checking.
- Sits between the multicycle core's MEM stage and on-chip data storage, replacing the zero-latency RAM so the core can be tested against wait states.

Parameters:
- DEPTH_WORDS, 128, number of 32-bit words stored.
- BASE_ADDR, 32'h10010000, byte address of word 0.
- READ_LATENCY, 2, cycles from read acceptance edge to dReady; legal range 1..15.
- WRITE_LATENCY, 1, cycles from write acceptance edge to dReady; legal range 1..15.

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- MemRead  in  1  read request strobe
- MemWrite  in  1  write request strobe
- dAddress  in  32  byte address
- dWriteData  in  32  store data
- dReadData  out  32  load data, valid while dReady=1 on a read
- dReady  out  1  one-cycle completion pulse
- dBusy  out  1  request in progress; new strobes ignored
- dError  out  1  pulses with dReady when the completed request was illegal

Behaviour:
- Reset (async, active-high): state=IDLE; dReadData=0, dReady=0, dBusy=0, dError=0; latency counter=0; captured request cleared. Memory contents are not cleared. Reset mid-operation aborts the request, and a pending write is NOT committed.
- States:
  - IDLE: dBusy=0. If MemRead|MemWrite is high at an edge, capture op, address and data; load counter with LAT-1; go to WAIT, or to RESP if LAT=1.
  - WAIT: dBusy=1; counter decrements each edge; go to RESP when counter reaches 0.
  - RESP: dBusy=1, dReady=1 for exactly one cycle; next state IDLE.
- Latency: with acceptance edge E, dReady is high in the cycle starting LAT edges after E. A back-to-back request is accepted at the edge ending the first IDLE cycle after RESP.
- Legality is decoded at acceptance:
  - offset = dAddress - BASE_ADDR, computed with 32-bit unsigned wrap.
  - in_range = offset < DEPTH_WORDS*4.
  - aligned = dAddress[1:0]==0.
  - both = MemRead & MemWrite.
  - Request is illegal if !in_range, !aligned, or both.
- Legal write: array[offset>>2] <= captured data at the edge entering RESP. The new value is visible to any read accepted afterwards.
- Legal read: array[offset>>2] is registered into dReadData at the edge entering RESP.
- Illegal request: no array access; dError=1 with dReady. For a read, or for both strobes, dReadData=32'h00000000.
- dReadData holds its last value outside RESP, except after reset.
- Strobes high during WAIT or RESP are ignored, not queued. A strobe still high in IDLE is accepted again as a new request; the requester must drop it after dReady.
- Offset wrap: an address below BASE_ADDR wraps to a huge offset and is therefore out of range.

Decomposition:
- Shared package dmem_pkg holds:
  - state encoding IDLE/WAIT/RESP (2-bit);
  - op enum (OP_READ, OP_WRITE, OP_BAD);
  - constant ERR_RDATA=32'h0;
  - latency counter width = 4.
- One sub-module, dmem_array: synchronous single-port word RAM (DEPTH_WORDS x 32, one we, registered read). The FSM and address decode stay in data_mem_responder.

Test Plan:
- Write then read: MemWrite, dAddress=BASE_ADDR+8, dWriteData=32'hCAFEF00D, with WRITE_LATENCY=1 -> dReady the cycle after acceptance, dError=0. Then MemRead at the same address with READ_LATENCY=2 -> dReady exactly 2 cycles after acceptance, dReadData=32'hCAFEF00D.
- Latency sweep: READ_LATENCY in {1,3,15} -> dBusy high from the acceptance edge through the dReady cycle; dReady is exactly one cycle wide, LAT cycles after acceptance.
- Illegal requests, each producing dReady with dError=1 and no array change:
  - dAddress=BASE_ADDR+DEPTH_WORDS*4 (first out-of-range word);
  - dAddress=BASE_ADDR+2 (misaligned);
  - dAddress=BASE_ADDR-4 (wrap);
  - MemRead=MemWrite=1.
  For the reads, dReadData=0. A follow-up read of BASE_ADDR returns its prior value.
- Busy ignore: a second MemWrite to BASE_ADDR+4 issued during WAIT of a read -> not executed; a read of BASE_ADDR+4 afterwards returns the old data.
- Reset mid-write: MemWrite with WRITE_LATENCY=3, rst asserted asynchronously (mid-cycle) in WAIT -> dBusy, dReady and dError drop immediately; the target word is unchanged on a later read.
- Boundary word: write and read at BASE_ADDR+(DEPTH_WORDS-1)*4 -> data returned, dError=0.

Source files
------------

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared state/op encodings and constants for the data-memory responder
package dmem_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  typedef enum logic [1:0] {OP_READ, OP_WRITE, OP_BAD} op_t;
  localparam logic [31:0] ERR_RDATA = 32'h0;
  localparam int CNT_W = 4;
endpackage

// File: rtl/dmem_array.sv
// dmem_array: single-port DEPTH x 32 word RAM (clk, rst clears read register, we/re, addr, wdata, rdata)
module dmem_array #(
  parameter int DEPTH = 128,
  parameter int AW = 7
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic          re,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);
  logic [31:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (we) mem[addr] <= wdata;
  always_ff @(posedge clk or posedge rst)
    if (rst) rdata <= '0;
    else if (re) rdata <= mem[addr];
endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder: latency-configurable data RAM responder (MemRead/MemWrite/dAddress/dWriteData in; dReadData/dReady/dBusy/dError out)
module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int          DEPTH_WORDS   = 128,
  parameter logic [31:0] BASE_ADDR     = 32'h10010000,
  parameter int          READ_LATENCY  = 2,
  parameter int          WRITE_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] dAddress,
  input  logic [31:0] dWriteData,
  output logic [31:0] dReadData,
  output logic        dReady,
  output logic        dBusy,
  output logic        dError
);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [31:0] SPAN = 32'(DEPTH_WORDS * 4);
  state_t state, state_n;
  op_t op_q, op_in, op_cur;
  logic [CNT_W-1:0] cnt, cnt_n, lat;
  logic [AW-1:0] idx_q, idx_in, idx_cur;
  logic [31:0] data_q, data_cur, offset, arr_rdata;
  logic rd_q, rd_cur, zero_q, accept, go_resp, we, re;
  assign offset = dAddress - BASE_ADDR;
  assign idx_in = offset[AW+1:2];
  assign op_in = (offset >= SPAN || dAddress[1:0] != 2'b00 || (MemRead && MemWrite)) ? OP_BAD :
                 MemWrite ? OP_WRITE : OP_READ;
  assign lat = CNT_W'(((MemWrite && !MemRead) ? WRITE_LATENCY : READ_LATENCY) - 1);
  assign accept = state == IDLE && (MemRead || MemWrite);
  // a latency-1 request completes at its own acceptance edge, so use the live request then
  assign op_cur = state == IDLE ? op_in : op_q;
  assign idx_cur = state == IDLE ? idx_in : idx_q;
  assign data_cur = state == IDLE ? dWriteData : data_q;
  assign rd_cur = state == IDLE ? MemRead : rd_q;
  assign go_resp = (accept && lat == '0) || (state == WAIT && cnt == CNT_W'(1));
  assign we = go_resp && op_cur == OP_WRITE;
  assign re = go_resp && op_cur == OP_READ;
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    case (state)
      IDLE: if (accept) begin
        state_n = lat == '0 ? RESP : WAIT;
        cnt_n = lat;
      end
      WAIT: begin
        cnt_n = cnt - CNT_W'(1);
        state_n = cnt == CNT_W'(1) ? RESP : WAIT;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      op_q <= OP_READ;
      idx_q <= '0;
      data_q <= '0;
      rd_q <= 1'b0;
      zero_q <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      if (accept) begin
        op_q <= op_in;
        idx_q <= idx_in;
        data_q <= dWriteData;
        rd_q <= MemRead;
      end
      // an illegal read forces zero until the next legal read refreshes the RAM register
      if (go_resp && (re || (op_cur == OP_BAD && rd_cur))) zero_q <= !re;
    end
  dmem_array #(.DEPTH(DEPTH_WORDS), .AW(AW)) u_array (
    .clk(clk), .rst(rst), .we(we), .re(re), .addr(idx_cur), .wdata(data_cur), .rdata(arr_rdata)
  );
  assign dReady = state == RESP;
  assign dBusy = state != IDLE;
  assign dError = dReady && op_q == OP_BAD;
  assign dReadData = zero_q ? ERR_RDATA : arr_rdata;
endmodule
